// File: rtl/press_count_display.sv
// rtl/press_count_display.sv - BCD press counter with multiplexed seven-segment display
module press_count_display #(
   parameter int DIGITS       = 4,
   parameter int REFRESH_BITS = 16,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  inc,
   input  logic                  dec,
   input  logic                  clr,
   output logic [4*DIGITS-1:0]   count_bcd,
   output logic                  wrap,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an
);

   localparam int   IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic OFF   = ACTIVE_LOW ? 1'b1 : 1'b0;

   logic [REFRESH_BITS-1:0] prescaler;
   logic [IDX_W-1:0]        idx;
   logic [4*DIGITS-1:0]     nxt_count;
   logic                    nxt_wrap;
   logic                    carry;
   logic [3:0]              d;
   logic [DIGITS-1:0]       blank_mask;
   logic                    zero_above;
   logic [3:0]              cur_digit;
   logic [6:0]              seg_hi;
   logic [DIGITS-1:0]       an_hi;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      case (v)
         4'd0:    seg_decode = 7'h3F;
         4'd1:    seg_decode = 7'h06;
         4'd2:    seg_decode = 7'h5B;
         4'd3:    seg_decode = 7'h4F;
         4'd4:    seg_decode = 7'h66;
         4'd5:    seg_decode = 7'h6D;
         4'd6:    seg_decode = 7'h7D;
         4'd7:    seg_decode = 7'h07;
         4'd8:    seg_decode = 7'h7F;
         4'd9:    seg_decode = 7'h6F;
         default: seg_decode = 7'h00;
      endcase
   endfunction

   // Ripple carry/borrow; a carry out of the top digit is the wrap.
   always_comb begin
      nxt_count = count_bcd;
      nxt_wrap  = 1'b0;
      carry     = 1'b1;
      d         = 4'd0;
      if (clr) begin
         nxt_count = '0;
      end else if (inc && !dec) begin
         for (int i = 0; i < DIGITS; i++) begin
            d = count_bcd[4*i +: 4];
            if (carry) begin
               if (d == 4'd9) begin
                  nxt_count[4*i +: 4] = 4'd0;
               end else begin
                  nxt_count[4*i +: 4] = d + 4'd1;
                  carry = 1'b0;
               end
            end
         end
         nxt_wrap = carry;
      end else if (dec && !inc) begin
         for (int i = 0; i < DIGITS; i++) begin
            d = count_bcd[4*i +: 4];
            if (carry) begin
               if (d == 4'd0) begin
                  nxt_count[4*i +: 4] = 4'd9;
               end else begin
                  nxt_count[4*i +: 4] = d - 4'd1;
                  carry = 1'b0;
               end
            end
         end
         nxt_wrap = carry;
      end
   end

   // Digit i>0 is blank when it and every digit above it are zero.
   always_comb begin
      blank_mask = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above    = zero_above && (count_bcd[4*i +: 4] == 4'd0);
         blank_mask[i] = zero_above;
      end
      cur_digit = count_bcd[4*idx +: 4];
      seg_hi    = blank_mask[idx] ? 7'h00 : seg_decode(cur_digit);
      an_hi     = DIGITS'(1) << idx;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_bcd <= '0;
         wrap      <= 1'b0;
         prescaler <= '0;
         idx       <= '0;
         seg       <= {7{OFF}};
         dp        <= OFF;
         an        <= {DIGITS{OFF}};
      end else begin
         count_bcd <= nxt_count;
         wrap      <= nxt_wrap;
         prescaler <= prescaler + 1'b1;
         if (&prescaler) begin
            if (idx == IDX_W'(DIGITS - 1))
               idx <= '0;
            else
               idx <= idx + 1'b1;
         end
         seg <= ACTIVE_LOW ? ~seg_hi : seg_hi;
         dp  <= OFF;
         an  <= ACTIVE_LOW ? ~an_hi : an_hi;
      end
   end

endmodule
